// File: rtl/rect_search.sv
// Scans a latched ROWS x COLS binary matrix for the first checkerboard rectangle
// and offers its corner coordinates downstream over a valid/ready handshake.
module rect_search #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int IDXW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] m_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDXW-1:0]      r1,
    output logic [IDXW-1:0]      r2,
    output logic [IDXW-1:0]      c1,
    output logic [IDXW-1:0]      c2,
    output logic                 done,
    output logic                 none_found
);

    localparam int NBITS = ROWS * COLS;
    localparam int BW    = $clog2(NBITS) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NBITS-1:0]  r_mat;
    logic [IDXW-1:0]   r_sr1, r_sr2, r_sc1, r_sc2;
    logic [IDXW-1:0]   r_r1, r_r2, r_c1, r_c2;
    logic              r_valid, r_done, r_none;
    logic              w_m11, w_m12, w_m21, w_m22;
    logic              w_hit, w_last;

    // Cell m[r][c] sits at bit (NBITS-1)-(r*COLS+c); a shift avoids an oversized index.
    function automatic logic cellAt(input logic [NBITS-1:0] mat,
                                    input logic [IDXW-1:0]  r,
                                    input logic [IDXW-1:0]  c);
        logic [BW-1:0]    idx;
        logic [NBITS-1:0] sh;
        idx = BW'(NBITS - 1) - (BW'(r) * BW'(COLS) + BW'(c));
        sh  = mat >> idx;
        return sh[0];
    endfunction

    assign w_m11 = cellAt(r_mat, r_sr1, r_sc1);
    assign w_m12 = cellAt(r_mat, r_sr1, r_sc2);
    assign w_m21 = cellAt(r_mat, r_sr2, r_sc1);
    assign w_m22 = cellAt(r_mat, r_sr2, r_sc2);

    assign w_hit  = (w_m11 == w_m22) && (w_m12 == w_m21) && (w_m11 != w_m12);
    assign w_last = (r_sr1 == IDXW'(ROWS - 2)) && (r_sr2 == IDXW'(ROWS - 1)) &&
                    (r_sc1 == IDXW'(COLS - 2)) && (r_sc2 == IDXW'(COLS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (w_hit) w_next = HOLD;
                     else if (w_last) w_next = IDLE;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: matrix latch, candidate walk (r1, r2, c1, c2 ascending), result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mat   <= '0;
            r_sr1   <= '0;
            r_sr2   <= '0;
            r_sc1   <= '0;
            r_sc2   <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_none  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mat  <= m_in;
                        r_sr1  <= '0;
                        r_sr2  <= IDXW'(1);
                        r_sc1  <= '0;
                        r_sc2  <= IDXW'(1);
                        r_none <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_r1    <= r_sr1;
                        r_r2    <= r_sr2;
                        r_c1    <= r_sc1;
                        r_c2    <= r_sc2;
                        r_valid <= 1'b1;
                    end else if (w_last) begin
                        r_done <= 1'b1;
                        r_none <= 1'b1;
                    end else if (r_sc2 != IDXW'(COLS - 1)) begin
                        r_sc2 <= r_sc2 + IDXW'(1);
                    end else if (r_sc1 != IDXW'(COLS - 2)) begin
                        r_sc1 <= r_sc1 + IDXW'(1);
                        r_sc2 <= r_sc1 + IDXW'(2);
                    end else if (r_sr2 != IDXW'(ROWS - 1)) begin
                        r_sr2 <= r_sr2 + IDXW'(1);
                        r_sc1 <= '0;
                        r_sc2 <= IDXW'(1);
                    end else begin
                        r_sr1 <= r_sr1 + IDXW'(1);
                        r_sr2 <= r_sr1 + IDXW'(2);
                        r_sc1 <= '0;
                        r_sc2 <= IDXW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign out_valid  = r_valid;
    assign r1         = r_r1;
    assign r2         = r_r2;
    assign c1         = r_c1;
    assign c2         = r_c2;
    assign done       = r_done;
    assign none_found = r_none;

endmodule

// File: tb/tb_rect_search.sv
// Directed-vector bench for rect_search at the default 4x4 size.
module tb_rect_search;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] m_in;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  r1, r2, c1, c2;
    logic        done;
    logic        none_found;

    int checkCount = 0;
    int failCount  = 0;
    logic sawValid;

    rect_search #(.ROWS(4), .COLS(4), .IDXW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .m_in       (m_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .r1         (r1),
        .r2         (r2),
        .c1         (c1),
        .c2         (c2),
        .done       (done),
        .none_found (none_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] mat);
        m_in  = mat;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic checkCoords(input string tag, input logic [1:0] er1, input logic [1:0] er2,
                               input logic [1:0] ec1, input logic [1:0] ec2);
        checkOutput({tag, "_coords"}, {24'd0, r1, r2, c1, c2}, {24'd0, er1, er2, ec1, ec2});
    endtask

    task automatic checkExhaust(input string tag, input logic [15:0] mat);
        applyStimulus(mat);
        checkOutput({tag, "_none_cleared"}, 32'(none_found), 32'd0);
        sawValid = 1'b0;
        for (int i = 1; i < 36; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
        tick();
        if (out_valid) sawValid = 1'b1;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_none"}, 32'(none_found), 32'd1);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_never_valid"}, 32'(sawValid), 32'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_none_held"}, 32'(none_found), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        m_in      = 16'h0000;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_outs", {26'd0, busy, out_valid, done, none_found, 2'b00},
                    32'd0);
        checkCoords("reset", 2'd0, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        tick();

        // First candidate hits; held 5 cycles with m_in disturbed.
        applyStimulus(16'h8400);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_valid_e0", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1_valid_e1", 32'(out_valid), 32'd1);
        checkCoords("t1", 2'd0, 2'd1, 2'd0, 2'd1);
        m_in = 16'h0021;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t1_hold_valid", 32'(out_valid), 32'd1);
        checkCoords("t1_hold", 2'd0, 2'd1, 2'd0, 2'd1);
        checkOutput("t1_hold_done", 32'(done), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("t1_idle", 32'(busy), 32'd0);
        checkOutput("t1_none", 32'(none_found), 32'd0);
        tick();
        checkOutput("t1_done_pulse", 32'(done), 32'd0);

        // Last candidate hits; a start pulse mid-scan and in HOLD is ignored.
        applyStimulus(16'h0021);
        for (int i = 1; i < 36; i++) begin
            if (i == 5) begin
                m_in  = 16'h8400;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checkOutput("t2_valid_e35", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t2_valid_e36", 32'(out_valid), 32'd1);
        checkCoords("t2", 2'd2, 2'd3, 2'd2, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkCoords("t2_hold_start", 2'd2, 2'd3, 2'd2, 2'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t2_done", 32'(done), 32'd1);
        tick();

        checkExhaust("zeros", 16'h0000);
        out_ready = 1'b1;
        checkExhaust("ones", 16'hFFFF);
        out_ready = 1'b0;

        // Reset mid-scan, then a clean restart.
        applyStimulus(16'h0000);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_outs", {26'd0, busy, out_valid, done, none_found, 2'b00},
                    32'd0);
        checkCoords("rst_mid", 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(16'h8400);
        tick();
        checkOutput("rst_restart_valid", 32'(out_valid), 32'd1);
        checkCoords("rst_restart", 2'd0, 2'd1, 2'd0, 2'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("rst_restart_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
